// File: rtl/disp_packet_buffer.sv
// -----------------------------------------------------------------------------
// disp_packet_buffer
//
// Result-packet FIFO feeding the DISPLAY stage. Packets leaving the processor
// ring are captured over an IN_SEND/IN_ACK handshake and held in a DEPTH-entry
// register FIFO. The oldest packet and the occupancy are shown to DISPLAY.
// A debounced press of the NEXT_SW push-button retires the head packet.
//
// Parameters:
//   DEPTH       FIFO entries, power of two, 2..16
//   DEB_CYCLES  consecutive stable synchronized samples to accept a button
//               level change (>= 2)
//
// Ports:
//   CLK         clock, rising edge
//   RST         asynchronous active-low reset
//   IN_SEND     upstream packet valid (level)
//   IN_PACKET   38-bit packet, stored unmodified
//   IN_ACK      buffer accepts IN_PACKET this cycle
//   NEXT_SW     raw bouncy push-button, 1 = pressed
//   PACKET_OUT  head packet, zero when empty
//   PC          occupancy 0..DEPTH
//   EMPTY       PC == 0
//   OVF         sticky overflow flag (only in drop-oldest build)
//
// Build option:
//   DISP_BUF_DROP_OLDEST_EN  when defined, IN_ACK is always 1 and a push into
//                            a full buffer overwrites the oldest entry and sets
//                            OVF. When undefined, a full buffer backpressures
//                            and OVF is tied to 0.
// -----------------------------------------------------------------------------
module disp_packet_buffer #(
  parameter int DEPTH      = 16,
  parameter int DEB_CYCLES = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        IN_SEND,
  input  logic [37:0] IN_PACKET,
  output logic        IN_ACK,
  input  logic        NEXT_SW,
  output logic [37:0] PACKET_OUT,
  output logic [4:0]  PC,
  output logic        EMPTY,
  output logic        OVF
);

  localparam int DATA_W = 38;
  localparam int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int DCW    = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [4:0]     FULL_CNT = 5'(DEPTH);
  localparam logic [DCW-1:0] DC_LAST  = DCW'(DEB_CYCLES - 1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wp;
  logic [AW-1:0]     rp;
  logic [4:0]        cnt;

  logic              s1;
  logic              s2;
  logic              deb;
  logic              deb_q;
  logic [DCW-1:0]    dc;

  logic              pop_pulse;
  logic              full;
  logic              nonempty;
  logic              push;
  logic              pop;
  logic              overwrite;

  // ---- button: synchronizer -> debouncer -> rising-edge detect ----
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      deb   <= 1'b0;
      deb_q <= 1'b0;
      dc    <= '0;
    end else begin
      s1    <= NEXT_SW;
      s2    <= s1;
      deb_q <= deb;
      // dc counts consecutive synchronized samples that disagree with deb;
      // any agreeing sample restarts the count, so bounces never accumulate.
      if (s2 == deb) begin
        dc <= '0;
      end else if (dc == DC_LAST) begin
        deb <= s2;
        dc  <= '0;
      end else begin
        dc <= dc + DCW'(1);
      end
    end
  end

  // Press edges only; a release edge never retires a packet.
  assign pop_pulse = deb & ~deb_q;

  // ---- FIFO control ----
  assign full     = (cnt == FULL_CNT);
  assign nonempty = (cnt != 5'd0);

`ifdef DISP_BUF_DROP_OLDEST_EN
  assign IN_ACK    = 1'b1;
  assign overwrite = IN_SEND & full;
`else
  assign IN_ACK    = ~full;
  assign overwrite = 1'b0;
`endif

  assign push = IN_SEND & IN_ACK;
  // A pop needs data present at this edge (a push into an empty buffer does
  // not count) and yields to an overwrite, which already advances rp.
  assign pop  = pop_pulse & nonempty & ~overwrite;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= 5'd0;
    end else begin
      if (push) begin
        wp <= wp + AW'(1);
      end
      if (pop || overwrite) begin
        rp <= rp + AW'(1);
      end
      // An overwrite keeps cnt at DEPTH; push and pop together cancel.
      case ({push & ~overwrite, pop})
        2'b10:   cnt <= cnt + 5'd1;
        2'b01:   cnt <= cnt - 5'd1;
        default: cnt <= cnt;
      endcase
    end
  end

  // ---- storage (data only, no reset) ----
  always_ff @(posedge CLK) begin
    if (push) begin
      mem[wp] <= IN_PACKET;
    end
  end

`ifdef DISP_BUF_DROP_OLDEST_EN
  logic ovf_r;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      ovf_r <= 1'b0;
    end else if (overwrite) begin
      ovf_r <= 1'b1;
    end
  end

  assign OVF = ovf_r;
`else
  assign OVF = 1'b0;
`endif

  // ---- outputs to DISPLAY ----
  assign PACKET_OUT = nonempty ? mem[rp] : '0;
  assign PC         = cnt;
  assign EMPTY      = ~nonempty;

endmodule

// File: tb/tb_disp_packet_buffer.sv
module tb_disp_packet_buffer;

  localparam int DEPTH      = 16;
  localparam int DEB_CYCLES = 4;

  logic        CLK       = 1'b0;
  logic        RST       = 1'b0;
  logic        IN_SEND   = 1'b0;
  logic [37:0] IN_PACKET = '0;
  logic        NEXT_SW   = 1'b0;
  logic        IN_ACK;
  logic [37:0] PACKET_OUT;
  logic [4:0]  PC;
  logic        EMPTY;
  logic        OVF;

  disp_packet_buffer #(.DEPTH(DEPTH), .DEB_CYCLES(DEB_CYCLES)) dut (
    .CLK(CLK), .RST(RST), .IN_SEND(IN_SEND), .IN_PACKET(IN_PACKET),
    .IN_ACK(IN_ACK), .NEXT_SW(NEXT_SW), .PACKET_OUT(PACKET_OUT),
    .PC(PC), .EMPTY(EMPTY), .OVF(OVF)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic        ack;
    logic [4:0]  pc;
    logic        empty;
    logic        ovf;
    logic [37:0] pkt;
  } obs_t;

  obs_t exp_q[$];
  obs_t mon_e;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  // Reference model: a packet queue plus a button model that tracks raw
  // samples two edges late and flips its debounced level after DEB_CYCLES
  // consecutive disagreeing samples.
  logic [37:0] mq[$];
  bit          h1, h2, deb_lvl, pop_req, ovf_m;
  int          run;

  // Stimulus state
  logic [37:0] cur_pkt;
  bit          pending = 1'b0;
  int          seq     = 0;

  function automatic logic [37:0] mk_pkt(input logic [15:0] data);
    return {3'($urandom), 8'($urandom), 7'($urandom), 4'($urandom), data};
  endfunction

  function automatic void chk(input string name, input logic [37:0] got, input logic [37:0] expv);
    total++;
    if (got !== expv) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, got, expv);
    end
  endfunction

  function automatic obs_t model_obs();
    obs_t o;
`ifdef DISP_BUF_DROP_OLDEST_EN
    o.ack = 1'b1;
`else
    o.ack = (mq.size() != DEPTH);
`endif
    o.pc    = 5'(mq.size());
    o.empty = (mq.size() == 0);
    o.ovf   = ovf_m;
    o.pkt   = (mq.size() != 0) ? mq[0] : 38'd0;
    return o;
  endfunction

  function automatic void model_step(input bit rst_n, input bit send, input logic [37:0] pkt,
                                     input bit sw, output bit acc);
    bit seen;
    bit do_pop;
    bit is_full;
    acc = 1'b0;
    if (!rst_n) begin
      mq.delete();
      h1 = 0; h2 = 0; deb_lvl = 0; pop_req = 0; ovf_m = 0; run = 0;
      return;
    end
    is_full = (mq.size() == DEPTH);
    do_pop  = pop_req && (mq.size() != 0);
`ifdef DISP_BUF_DROP_OLDEST_EN
    if (send && is_full) begin
      void'(mq.pop_front());
      mq.push_back(pkt);
      ovf_m = 1'b1;
      acc   = 1'b1;
    end else begin
      if (do_pop) void'(mq.pop_front());
      if (send) begin
        mq.push_back(pkt);
        acc = 1'b1;
      end
    end
`else
    if (do_pop) void'(mq.pop_front());
    if (send && !is_full) begin
      mq.push_back(pkt);
      acc = 1'b1;
    end
`endif
    seen = h2;
    h2   = h1;
    h1   = sw;
    pop_req = 1'b0;
    if (seen != deb_lvl) run++;
    else run = 0;
    if (run == DEB_CYCLES) begin
      deb_lvl = seen;
      run     = 0;
      pop_req = seen;
    end
  endfunction

  task automatic cycle(input bit send, input logic [37:0] pkt, input bit sw, output bit acc);
    IN_SEND   = send;
    IN_PACKET = pkt;
    NEXT_SW   = sw;
    @(posedge CLK);
    model_step(RST, send, pkt, sw, acc);
    exp_q.push_back(model_obs());
    #1;
  endtask

  // Sends cur_pkt when asked, and keeps offering it until it is accepted.
  task automatic step(input bit want, input bit sw);
    bit acc;
    bit snd;
    snd = want || pending;
    cycle(snd, cur_pkt, sw, acc);
    if (acc) begin
      pending = 1'b0;
      seq++;
      cur_pkt = mk_pkt(16'(seq));
    end else begin
      pending = snd;
    end
  endtask

  task automatic press(input int n_on, input int n_off);
    for (int k = 0; k < n_on; k++) step(1'b0, 1'b1);
    for (int k = 0; k < n_off; k++) step(1'b0, 1'b0);
  endtask

  task automatic do_reset(input int n);
    bit acc;
    @(negedge CLK);
    #1;
    RST     = 1'b0;
    pending = 1'b0;
    for (int k = 0; k < n; k++) cycle(1'b1, cur_pkt, 1'b0, acc);
    RST = 1'b1;
  endtask

  // Monitor: one expected observation per clock, compared mid-cycle.
  initial begin
    forever begin
      @(negedge CLK);
      cyc++;
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        chk("in_ack", 38'(IN_ACK), 38'(mon_e.ack));
        chk("pc", 38'(PC), 38'(mon_e.pc));
        chk("empty", 38'(EMPTY), 38'(mon_e.empty));
        chk("ovf", 38'(OVF), 38'(mon_e.ovf));
        chk("packet_out", PACKET_OUT, mon_e.pkt);
      end
    end
  end

  initial begin
    bit          acc;
    logic [37:0] p_a;
    logic [37:0] p_b;
    bit          sw_lvl;
    int          sw_left;

    // Reset held two cycles with IN_SEND high.
    RST     = 1'b0;
    cur_pkt = mk_pkt(16'hdead);
    for (int k = 0; k < 2; k++) cycle(1'b1, cur_pkt, 1'b0, acc);
    chk("rst_ack", 38'(IN_ACK), 38'd1);
    chk("rst_pc", 38'(PC), 38'd0);
    chk("rst_empty", 38'(EMPTY), 38'd1);
    chk("rst_pkt", PACKET_OUT, 38'd0);
    RST = 1'b1;

    seq = 7;
    cur_pkt = mk_pkt(16'd7);
    p_a = cur_pkt;
    step(1'b1, 1'b0);
    chk("first_pc", 38'(PC), 38'd1);
    chk("first_pkt", PACKET_OUT, p_a);
    press(10, 10);
    chk("first_pop_pc", 38'(PC), 38'd0);

    // Order and pop timing.
    seq = 120;
    cur_pkt = mk_pkt(16'd120);
    for (int k = 0; k < 3; k++) step(1'b1, 1'b0);
    chk("order_pc3", 38'(PC), 38'd3);
    chk("order_d120", 38'(PACKET_OUT[15:0]), 38'd120);
    for (int k = 1; k <= 10; k++) begin
      step(1'b0, 1'b1);
      if (k == 6) chk("pop1_edge6_pc", 38'(PC), 38'd3);
      if (k == 7) chk("pop1_edge7_pc", 38'(PC), 38'd2);
    end
    chk("order_d121", 38'(PACKET_OUT[15:0]), 38'd121);
    press(0, 10);
    for (int k = 1; k <= 10; k++) begin
      step(1'b0, 1'b1);
      if (k == 6) chk("pop2_edge6_pc", 38'(PC), 38'd2);
      if (k == 7) chk("pop2_edge7_pc", 38'(PC), 38'd1);
    end
    chk("order_d122", 38'(PACKET_OUT[15:0]), 38'd122);
    press(0, 10);

    // Bounce: toggle, then hold; exactly one pop, none on release.
    step(1'b1, 1'b0);
    chk("bounce_pre_pc", 38'(PC), 38'd2);
    for (int k = 0; k < 8; k++) step(1'b0, (k % 2) == 0);
    for (int k = 0; k < 12; k++) step(1'b0, 1'b1);
    chk("bounce_hold_pc", 38'(PC), 38'd1);
    for (int k = 0; k < 12; k++) step(1'b0, 1'b0);
    chk("bounce_rel_pc", 38'(PC), 38'd1);

    // Empty pop.
    press(10, 10);
    press(10, 10);
    chk("empty_press_pc", 38'(PC), 38'd0);

    // Push and pop on the same edge with two stored.
    p_a = cur_pkt;
    step(1'b1, 1'b0);
    p_b = cur_pkt;
    step(1'b1, 1'b0);
    chk("simul_pre_head", PACKET_OUT, p_a);
    for (int k = 1; k <= 10; k++) begin
      step(k == 7, 1'b1);
      if (k == 7) begin
        chk("simul_pc", 38'(PC), 38'd2);
        chk("simul_head", PACKET_OUT, p_b);
      end
    end
    press(0, 10);

    // Full.
    do_reset(2);
    seq = 0;
    cur_pkt = mk_pkt(16'd0);
    for (int k = 0; k < 17; k++) step(1'b1, 1'b0);
    chk("full_pc", 38'(PC), 38'd16);
`ifdef DISP_BUF_DROP_OLDEST_EN
    chk("full_ovf", 38'(OVF), 38'd1);
    chk("full_head_d1", 38'(PACKET_OUT[15:0]), 38'd1);
    press(10, 10);
    chk("full_pop_pc", 38'(PC), 38'd15);
`else
    chk("full_ack", 38'(IN_ACK), 38'd0);
    for (int k = 1; k <= 10; k++) begin
      step(1'b0, 1'b1);
      if (k == 7) chk("full_pop_pc", 38'(PC), 38'd15);
      if (k == 8) chk("full_refill_pc", 38'(PC), 38'd16);
    end
    chk("full_head_d1", 38'(PACKET_OUT[15:0]), 38'd1);
    press(0, 10);
`endif

    // Randomized traffic with occasional mid-stream resets.
    sw_lvl  = 1'b0;
    sw_left = 0;
    for (int i = 0; i < 2400; i++) begin
      if ((i % 800) == 400) do_reset(2);
      if (sw_left == 0) begin
        sw_lvl  = ~sw_lvl;
        sw_left = $urandom_range(1, 12);
      end
      sw_left--;
      step($urandom_range(0, 15) < (((i / 300) % 2) != 0 ? 8 : 1), sw_lvl);
    end

    repeat (2) @(negedge CLK);
    #1;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain left=%0d exp=0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/disp_packet_buffer.md
# disp_packet_buffer

Result-packet buffer that sits directly upstream of the DISPLAY stage. Captures 38-bit result packets leaving the processor ring over a send/ack handshake and stores them in a DEPTH-entry FIFO. Presents the oldest packet and the current occupancy to DISPLAY on PACKET_OUT/PC. Advances to the next packet on a debounced press of a dedicated "next" button.

## Interface
- DEPTH, 16: FIFO entries; power of two, 2..16.
- DEB_CYCLES, 4: consecutive stable synchronized samples needed to accept a button level change; minimum 2.
- CLK  in  1  single clock; all state updates on rising edge.
- RST  in  1  asynchronous, active-low reset; clears all state immediately.
- IN_SEND  in  1  upstream packet valid (level).
- IN_PACKET  in  38  packet {dest[2:0], gen[7:0], node[6:0], flag3..flag0, data[15:0]}; stored unmodified.
- IN_ACK  out  1  buffer accepts IN_PACKET this cycle.
- NEXT_SW  in  1  raw, asynchronous, bouncy push-button; 1 = pressed.
- PACKET_OUT  out  38  head packet to DISPLAY.PACKET_IN; 38'd0 when empty.
- PC  out  5  occupancy 0..DEPTH to DISPLAY.PC.
- EMPTY  out  1  PC == 0.
- OVF  out  1  sticky overflow flag (see Configuration).

## Operation
- Storage: DEPTH x 38 register array, write pointer wp, read pointer rp (log2 DEPTH bits, wrap modulo DEPTH), counter cnt (5 bits).
- Push: occurs when IN_SEND & IN_ACK at a rising edge. Writes mem[wp], increments wp, increments cnt.
- IN_ACK = (cnt != DEPTH). It is combinational from registered cnt only and never depends on IN_SEND.
- Button path: two-flop synchronizer s1 -> s2, then a debouncer with state deb and counter dc.
  - When s2 == deb: dc <= 0.
  - When s2 != deb: dc increments. When dc reaches DEB_CYCLES-1, deb <= s2 and dc <= 0.
- Pop pulse = deb & ~deb_q, where deb_q is deb delayed one cycle. The pulse is one cycle wide. Release edges never pop.
- Pop: acts on a pop pulse only when cnt != 0 at that edge. It increments rp and decrements cnt. A pop pulse while empty is discarded and is not remembered.
- Simultaneous push and pop (not full): both pointers advance and cnt is unchanged.
- Push into an empty buffer with a pop pulse in the same cycle: the pop is ignored and cnt becomes 1.
- PACKET_OUT = mem[rp] when cnt != 0, else 0. It is combinational from registers.
- PC = cnt. EMPTY = (cnt == 0).
- Reset values:
  - wp, rp, cnt, dc = 0; s1, s2, deb, deb_q = 0; OVF = 0.
  - Outputs after reset: IN_ACK = 1, PC = 0, EMPTY = 1, PACKET_OUT = 0.
  - Memory contents are don't-care.
- Reset mid-handshake discards buffered data. A packet whose push edge coincides with reset assertion is lost.

## Timing
- Push latency: a packet accepted at edge N appears on PACKET_OUT and PC after edge N if the buffer was empty.
- Throughput: one push per cycle while not full.
- Button latency: take edge 1 as the first edge sampling NEXT_SW = 1, held continuously.
  - s2 = 1 after edge 2.
  - deb = 1 after edge DEB_CYCLES+2.
  - Pop takes effect at edge DEB_CYCLES+3 (edge 7 at default).
- A pulse on NEXT_SW shorter than DEB_CYCLES synchronized samples causes no pop.
- Full: IN_ACK drops after the edge that makes cnt == DEPTH. It rises after the first pop.
- Full with a pop pulse in the same cycle: no push that cycle because IN_ACK = 0. The pop completes, and IN_ACK = 1 in the next cycle.

## Configuration
- DISP_BUF_DROP_OLDEST_EN defined:
  - IN_ACK is tied to 1.
  - A push while cnt == DEPTH overwrites the oldest entry: mem[wp] written, wp and rp both increment, cnt stays DEPTH.
  - That event sets OVF. OVF clears only on reset.
  - A pop pulse in the same cycle as an overwrite is ignored.
- Macro undefined: backpressure behaviour as in Operation, and OVF is tied to 0.

## Test plan
- Reset: hold RST = 0 for 2 cycles with IN_SEND = 1. Required: IN_ACK = 1, PC = 0, EMPTY = 1, PACKET_OUT = 0, and nothing stored. After release, the first push sets PC = 1 and PACKET_OUT to the sent packet on the next cycle.
- Order: push 3 packets with data 16'd120, 16'd121, 16'd122. Press NEXT_SW for 10 cycles, twice. Required:
  - PC sequence 3 -> 2 -> 1.
  - PACKET_OUT data sequence 120 -> 121 -> 122.
  - Each pop occurs exactly at the 7th edge after press.
- Bounce: toggle NEXT_SW 1/0 every cycle for 8 cycles, then hold 1. Required: exactly one pop. No pop on release.
- Full without macro: push 16 packets with IN_SEND held. Required:
  - IN_ACK = 0 after the 16th push and PC = 16.
  - A 17th packet is held, not lost.
  - After one pop the 17th packet is accepted and PC returns to 16.
- Full with DISP_BUF_DROP_OLDEST_EN: push 17 packets with data 0..16. Required: PC = 16, PACKET_OUT data = 1, OVF = 1.
- Empty pop and simultaneous events:
  - Press while empty: PC stays 0.
  - Push plus pop pulse in the same cycle with PC = 2: PC stays 2 and the head advances.
